flit_delta_encoder: RTL and testbench

Downstream stage of the per-flit minimum finder in the Flitzip compression path. It takes a 128-bit flit together with the 8-bit minimum chunk value (the base) computed for that flit. It produces a base-delta compressed frame: a width code, the base, and sixteen W-bit deltas. The frame is serialized onto a 32-bit output bus with a valid/ready handshake, and the block falls back to a raw frame when the supplied base is not a true lower bound.

---
 rtl/flit_delta_encoder.sv | 143 ++++++++++++++
 tb/tb_flit_delta_encoder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_delta_encoder.sv
// flit_delta_encoder
// Base-delta compressor for one 128-bit flit. The captured flit and its
// minimum chunk (base) are turned into a frame: a 4-bit width code W,
// the base, and sixteen W-bit deltas. If the base is not a true lower
// bound, a raw frame (code 4'hF followed by the flit) is sent instead.
// The frame goes out LSB first as 32-bit beats.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// Once out_valid is high, data_out/out_last hold until that beat transfers.
// in_ready is high only in IDLE.
//
// Ports:
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   flit_in, base_in        flit and its base, qualified by in_valid
//   in_valid / in_ready     input handshake
//   data_out, out_last      current beat, last-beat flag
//   out_valid / out_ready   output handshake
//   dbg_state_o             current FSM state (0=IDLE, 1=CALC, 2=SEND)
module flit_delta_encoder #(
   parameter int FLIT_WIDTH = 128,
   parameter int D          = 8,
   parameter int N_CHUNK    = 16,
   parameter int OUT_WIDTH  = 32
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic [FLIT_WIDTH-1:0] flit_in,
   input  logic [D-1:0]          base_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [OUT_WIDTH-1:0]  data_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic [1:0]            dbg_state_o
);

   localparam int MAX_BEATS = 5;
   localparam int FRAME_W   = MAX_BEATS * OUT_WIDTH;

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, SEND = 2'd2} state_t;

   state_t                state_q;
   logic [FLIT_WIDTH-1:0] flit_q;
   logic [D-1:0]          base_q;
   logic [FRAME_W-1:0]    frame_q;
   logic [2:0]            beats_q;
   logic [2:0]            k_q;
   logic                  out_valid_q;
   logic                  out_last_q;

   logic [D-1:0]          delta_d [N_CHUNK];
   logic [D-1:0]          max_d;
   logic                  raw_d;
   logic [3:0]            w_d;
   logic [FRAME_W-1:0]    frame_d;
   logic [2:0]            beats_d;

   // Frame builder, evaluated from the captured flit during CALC.
   always_comb begin
      raw_d   = 1'b0;
      max_d   = '0;
      w_d     = '0;
      frame_d = '0;
      beats_d = '0;
      for (int i = 0; i < N_CHUNK; i++) begin
         delta_d[i] = flit_q[i*D +: D] - base_q;
         if (flit_q[i*D +: D] < base_q) raw_d = 1'b1;
         if (delta_d[i] > max_d) max_d = delta_d[i];
      end
      // Bit-length of the largest delta: position of its highest set bit + 1.
      for (int b = 0; b < D; b++) begin
         if (max_d[b]) w_d = 4'(b + 1);
      end
      if (raw_d) begin
         frame_d = {{(FRAME_W-FLIT_WIDTH-4){1'b0}}, flit_q, 4'hF};
         beats_d = 3'(MAX_BEATS);
      end else begin
         frame_d = FRAME_W'(w_d) | (FRAME_W'(base_q) << 4);
         // Each delta fits in W bits, so OR-ing at its offset needs no masking.
         for (int i = 0; i < N_CHUNK; i++) begin
            frame_d = frame_d | (FRAME_W'(delta_d[i]) << (12 + i * int'(w_d)));
         end
         beats_d = 3'((12 + N_CHUNK * int'(w_d) + OUT_WIDTH - 1) / OUT_WIDTH);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= IDLE;
         flit_q      <= '0;
         base_q      <= '0;
         frame_q     <= '0;
         beats_q     <= '0;
         k_q         <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  flit_q  <= flit_in;
                  base_q  <= base_in;
                  state_q <= CALC;
               end
            end
            CALC: begin
               frame_q     <= frame_d;
               beats_q     <= beats_d;
               k_q         <= '0;
               out_valid_q <= 1'b1;
               out_last_q  <= (beats_d == 3'd1);
               state_q     <= SEND;
            end
            SEND: begin
               if (out_ready) begin
                  if (out_last_q) begin
                     state_q     <= IDLE;
                     frame_q     <= '0;
                     k_q         <= '0;
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                  end else begin
                     // The current beat always sits in the low word of frame_q.
                     frame_q    <= frame_q >> OUT_WIDTH;
                     k_q        <= k_q + 3'd1;
                     out_last_q <= (3'(k_q + 3'd2) == beats_q);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Gated by rst_n_in so in_ready is low for the whole reset interval.
   assign in_ready    = rst_n_in && (state_q == IDLE);
   assign data_out    = frame_q[OUT_WIDTH-1:0];
   assign out_valid   = out_valid_q;
   assign out_last    = out_last_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_flit_delta_encoder.sv
module tb_flit_delta_encoder;

  logic         clk_in = 1'b0;
  logic         rst_n_in = 1'b0;
  logic [127:0] flit_in = '0;
  logic [7:0]   base_in = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  data_out;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_last;
  logic [1:0]   dbg_state_o;

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];   // {last, data}
  logic [31:0] got_q[$];
  int xfer_cnt = 0;
  logic auto_ready = 1'b0;
  logic manual_ready = 1'b1;

  flit_delta_encoder dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .flit_in(flit_in), .base_in(base_in),
    .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .dbg_state_o(dbg_state_o)
  );

  // clock / reset-free ready generator
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    #1;
    out_ready = auto_ready ? ($urandom_range(0, 3) != 0) : manual_ready;
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: frame from the compression rules, one bit at a time.
  task automatic model(input logic [127:0] f, input logic [7:0] b);
    logic [159:0] fr;
    logic [7:0] d [16];
    logic [7:0] mx;
    int w, nb;
    bit raw;
    raw = 0;
    mx = 0;
    for (int i = 0; i < 16; i++) begin
      if (f[8*i +: 8] < b) raw = 1;
      d[i] = f[8*i +: 8] - b;
      if (d[i] > mx) mx = d[i];
    end
    fr = '0;
    if (raw) begin
      fr[3:0] = 4'hF;
      fr[131:4] = f;
      nb = 5;
    end else begin
      w = 0;
      while ((int'(mx) >> w) != 0) w++;
      fr[3:0] = 4'(w);
      fr[11:4] = b;
      for (int i = 0; i < 16; i++)
        for (int j = 0; j < w; j++)
          fr[12 + i*w + j] = d[i][j];
      nb = (12 + 16*w + 31) / 32;
    end
    for (int k = 0; k < nb; k++)
      exp_q.push_back({(k == nb-1) ? 1'b1 : 1'b0, fr[32*k +: 32]});
  endtask

  // driver
  task automatic send_flit(input logic [127:0] f, input logic [7:0] b);
    int t;
    t = 0;
    @(posedge clk_in); #1;
    flit_in = f; base_in = b; in_valid = 1'b1;
    forever begin
      @(negedge clk_in);
      if (in_ready) break;
      t++;
      if (t > 300) begin
        chk("accept_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
    model(f, b);
    @(posedge clk_in); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(negedge clk_in);
      t++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    @(negedge clk_in);
  endtask

  // monitor / scoreboard
  logic prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic prev_last;
  always @(negedge clk_in) begin
    logic [32:0] e;
    if (rst_n_in) begin
      if (prev_stall) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_beat", {31'b0, out_last, data_out}, {31'b0, prev_last, prev_data});
      end
      if (out_valid) chk("in_ready_busy", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {31'b0, out_last, data_out}, 64'hDEAD_0000_0000_0000);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {31'b0, out_last, data_out}, {31'b0, e});
        end
        got_q.push_back(data_out);
        xfer_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = data_out;
      prev_last = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    logic [127:0] f, fb;
    logic [7:0] b, bb;
    int w, xb, t, maxv;

    // reset state
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // W=0: single beat, 2-cycle latency
    got_q.delete();
    send_flit({16{8'h05}}, 8'h05);
    @(negedge clk_in);
    chk("w0_calc_no_valid", 64'(out_valid), 64'd0);
    @(negedge clk_in);
    chk("w0_latency_valid", 64'(out_valid), 64'd1);
    chk("w0_data", 64'(data_out), 64'h50);
    chk("w0_last", 64'(out_last), 64'd1);
    @(negedge clk_in);
    chk("w0_in_ready_back", 64'(in_ready), 64'd1);
    drain();

    // W=4 ramp
    got_q.delete();
    for (int i = 0; i < 16; i++) f[8*i +: 8] = 8'(8'h10 + i);
    send_flit(f, 8'h10);
    drain();
    chk("w4_nbeats", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      chk("w4_beat0", 64'(got_q[0]), 64'h43210104);
      chk("w4_beat2_hi", 64'(got_q[2][31:12]), 64'd0);
    end

    // W=8, only chunk15 non-zero
    got_q.delete();
    f = '0; f[127:120] = 8'hFF;
    send_flit(f, 8'h00);
    drain();
    chk("w8_nbeats", 64'(got_q.size()), 64'd5);
    if (got_q.size() == 5) begin
      chk("w8_beat0", 64'(got_q[0]), 64'h8);
      chk("w8_beat4", 64'(got_q[4]), 64'hFF0);
    end

    // raw fallback
    got_q.delete();
    f = {$urandom, $urandom, $urandom, $urandom};
    f[7:0] = 8'h03;
    send_flit(f, 8'h04);
    drain();
    chk("raw_nbeats", 64'(got_q.size()), 64'd5);
    if (got_q.size() == 5) begin
      chk("raw_beat0", 64'(got_q[0]), 64'({f[27:0], 4'hF}));
      chk("raw_beat4", 64'(got_q[4]), 64'({28'b0, f[127:124]}));
    end

    // stall during beat1 of a W=4 frame, second flit waiting
    for (int i = 0; i < 16; i++) f[8*i +: 8] = 8'(8'h20 + (i % 16));
    fb = {$urandom, $urandom, $urandom, $urandom};
    bb = 8'h00;
    fork
      begin
        send_flit(f, 8'h20);
        send_flit(fb, bb);
      end
      begin
        t = 0;
        do begin
          @(negedge clk_in);
          t++;
        end while (!(out_valid && out_ready) && t < 100);
        manual_ready = 1'b0;
        repeat (3) @(negedge clk_in);
        manual_ready = 1'b1;
      end
    join
    drain();

    // reset during beat2 of a 5-beat frame
    f = '0; f[127:120] = 8'hFF;
    xb = xfer_cnt;
    send_flit(f, 8'h00);
    t = 0;
    while (xfer_cnt < xb + 2 && t < 100) begin
      @(negedge clk_in);
      t++;
    end
    @(posedge clk_in); #2;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n_in = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(data_out), 64'd0);
    chk("mid_rst_last", 64'(out_last), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    got_q.delete();
    for (int i = 0; i < 16; i++) f[8*i +: 8] = 8'(8'h10 + i);
    send_flit(f, 8'h10);
    drain();
    if (got_q.size() > 0) chk("after_rst_beat0", 64'(got_q[0]), 64'h43210104);
    else chk("after_rst_nbeats", 64'(got_q.size()), 64'd3);

    // randomized traffic with random backpressure
    auto_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      w = $urandom_range(0, 9);
      if (w == 9) begin
        b = 8'($urandom_range(1, 255));
        f = {$urandom, $urandom, $urandom, $urandom};
        f[8*$urandom_range(0, 15) +: 8] = 8'($urandom_range(0, int'(b) - 1));
      end else begin
        maxv = (1 << w) - 1;
        b = 8'($urandom_range(0, 255 - maxv));
        for (int i = 0; i < 16; i++) f[8*i +: 8] = 8'(int'(b) + $urandom_range(0, maxv));
      end
      send_flit(f, b);
    end
    drain();
    auto_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
